// File: rtl/enigma_input_ctrl.sv
// enigma_input_ctrl
//
// Command front-end for the Enigma core. The host raises a strobe on ui_in[7]
// with an opcode on ui_in[6:5] and a letter/position on ui_in[4:0]. The strobe
// is synchronised and edge-detected, and the command is validated and queued
// in a first-word-fall-through FIFO. From there it is offered to the core over
// a valid/ready handshake. Dropped commands raise sticky error flags.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ui_in        [7] strobe, [6:5] opcode, [4:0] data
//   cmd_valid    FIFO head holds a command
//   cmd_ready    core accepts the head this cycle
//   cmd_op       head opcode (0 when empty)
//   cmd_data     head data (0 when empty)
//   fifo_count   current FIFO occupancy
//   err_invalid  sticky: an illegal command was dropped
//   err_overflow sticky: a command was dropped because the FIFO was full
//   clr_err      synchronous clear of both sticky flags (a same-cycle set wins)
//
// Opcodes: 00 ENCRYPT, 01 SET_POS, 10 SET_RING (data must be 0..25),
//          11 RESET_ROTORS (always legal, data queued as 0).
//
// All outputs come from flops or the FIFO storage. There is no combinational
// path from ui_in or cmd_ready to any output.

module enigma_input_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DATA_W      = 5,
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH),
  localparam int unsigned CntW       = PtrW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        ui_in,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_op,
  output logic [DATA_W-1:0] cmd_data,
  output logic [CntW-1:0]   fifo_count,
  output logic              err_invalid,
  output logic              err_overflow,
  input  logic              clr_err
);

  localparam logic [1:0] OpResetRotors = 2'b11;
  localparam logic [4:0] MaxLetter     = 5'd25;

  // ---------------------------------------------------------------------------
  // Strobe synchroniser and rising-edge detect
  // ---------------------------------------------------------------------------
  // Every stage and the history flop reset to 1. A strobe that is already high
  // when reset is released then looks like a level, not a rising edge.
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   strobe_evt;

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], ui_in[7]};
    hist_d     = sync_q[SYNC_STAGES-1];
    strobe_evt = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture and validation
  // ---------------------------------------------------------------------------
  // The command field is sampled straight from the pins on the edge that
  // consumes strobe_evt. The host keeps it stable across the synchroniser
  // latency, so no extra capture register is needed.
  logic [1:0]        cap_op;
  logic [4:0]        cap_raw;
  logic [DATA_W-1:0] cap_data;
  logic              cmd_legal;

  always_comb begin
    cap_op    = ui_in[6:5];
    cap_raw   = ui_in[4:0];
    cmd_legal = (cap_op == OpResetRotors) || (cap_raw <= MaxLetter);
    cap_data  = (cap_op == OpResetRotors) ? '0 : DATA_W'(cap_raw);
  end

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            fifo_empty;
  logic            fifo_full;
  logic            pop;
  logic            push;
  logic            drop_invalid;
  logic            drop_overflow;

  always_comb begin
    fifo_empty    = (count_q == '0);
    fifo_full     = (count_q == CntW'(FIFO_DEPTH));
    pop           = ~fifo_empty & cmd_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push          = strobe_evt & cmd_legal & (~fifo_full | pop);
    drop_invalid  = strobe_evt & ~cmd_legal;
    drop_overflow = strobe_evt & cmd_legal & fifo_full & ~pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  logic [1:0]        op_mem_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        op_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (push) begin
      op_mem_q[wr_ptr_q]   <= cap_op;
      data_mem_q[wr_ptr_q] <= cap_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  logic err_inv_q, err_inv_d;
  logic err_ovf_q, err_ovf_d;

  always_comb begin
    // If a set and a clear fall on the same edge, the set wins.
    err_inv_d = (err_inv_q & ~clr_err) | drop_invalid;
    err_ovf_d = (err_ovf_q & ~clr_err) | drop_overflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_inv_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      err_inv_q <= err_inv_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cmd_valid    = ~fifo_empty;
    cmd_op       = fifo_empty ? '0 : op_mem_q[rd_ptr_q];
    cmd_data     = fifo_empty ? '0 : data_mem_q[rd_ptr_q];
    fifo_count   = count_q;
    err_invalid  = err_inv_q;
    err_overflow = err_ovf_q;
  end

endmodule
